// File: rtl/csr_if.sv
// Bus between the pipeline (ID read port, WB write port, commit events) and the
// machine-mode CSR file.
interface csr_if;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        wr_csr_n;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        trap;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic        retire;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        is_e_cause_eq_ecall;
  logic        illegal_csr;

  modport master (
    output csr_addr, wr_csr_n, wr_addr, wr_data, trap, trap_cause, trap_pc, mret, retire,
    input  csr_rdata, mtvec_out, mepc_out, is_e_cause_eq_ecall, illegal_csr
  );
  modport slave (
    input  csr_addr, wr_csr_n, wr_addr, wr_data, trap, trap_cause, trap_pc, mret, retire,
    output csr_rdata, mtvec_out, mepc_out, is_e_cause_eq_ecall, illegal_csr
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: combinational read port, single write port, trap/mret
// commit updates and free-running 64-bit cycle/instret counters.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  csr_if.slave bus
);
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [31:0] mstatus_rd, rdata;
  logic        unimpl, we, ro_wr;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign we         = !bus.wr_csr_n;

  always_comb begin
    rdata  = '0;
    unimpl = 1'b0;
    case (bus.csr_addr)
      12'h300: rdata = mstatus_rd;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'hB00, 12'hC00: rdata = mcycle_q[31:0];
      12'hB80, 12'hC80: rdata = mcycle_q[63:32];
      12'hB02, 12'hC02: rdata = minstret_q[31:0];
      12'hB82, 12'hC82: rdata = minstret_q[63:32];
      12'hF14: rdata = HART_ID;
      default: unimpl = 1'b1;
    endcase
  end

  always_comb begin
    ro_wr = 1'b0;
    case (bus.wr_addr)
      12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14: ro_wr = we;
      default: ro_wr = 1'b0;
    endcase
  end

  assign bus.csr_rdata           = rdata;
  assign bus.illegal_csr         = unimpl | ro_wr;
  assign bus.mtvec_out           = mtvec_q;
  assign bus.mepc_out            = mepc_q;
  assign bus.is_e_cause_eq_ecall = (mcause_q == 32'd11);

  // Priority trap > mret > CSR write, resolved per register.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, bus.retire};
    if (we) begin
      case (bus.wr_addr)
        12'h300: begin mie_d = bus.wr_data[3]; mpie_d = bus.wr_data[7]; end
        12'h305: mtvec_d    = {bus.wr_data[31:2], 2'b00};
        12'h340: mscratch_d = bus.wr_data;
        12'h341: mepc_d     = {bus.wr_data[31:2], 2'b00};
        12'h342: mcause_d   = bus.wr_data;
        // A half write freezes the whole counter for that cycle: no increment, no carry.
        12'hB00: mcycle_d   = {mcycle_q[63:32], bus.wr_data};
        12'hB80: mcycle_d   = {bus.wr_data, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], bus.wr_data};
        12'hB82: minstret_d = {bus.wr_data, minstret_q[31:0]};
        default: ;
      endcase
    end
    if (bus.trap) begin
      mepc_d   = {bus.trap_pc[31:2], 2'b00};
      mcause_d = bus.trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (bus.mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
endmodule
